execute_cycle: RTL and testbench

- Execute stage of the 16-bit five-stage pipeline. It sits directly downstream of decode_cycle and consumes its ID/EX outputs.
- Resolves operand forwarding, runs the ALU, resolves branch/jump and drives the PC redirect. Registers results into the EX/MEM pipeline register for the memory stage.
- Adds a 16-step iterative multiplier (ALUControl 3'b111). While it runs, BusyE requests a stall from the hazard unit.

---
 rtl/execute_cycle.sv | 167 ++++++++++++++++
 tb/tb_execute_cycle.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// Execute stage of the 16-bit five-stage pipeline: forwarding, ALU, branch
// resolution, 16-step iterative multiplier, and the EX/MEM pipeline register.
module execute_cycle #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             ALUSrcE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Imm_Ext_E,
  input  logic [AW-1:0]    RD_E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             BusyE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [AW-1:0]    RD_M,
  output logic [WIDTH-1:0] PCPlus4M
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [3:0]       count_q;
  logic [WIDTH-1:0] mcand_q, mult_q, acc_q;

  logic             regwrite_q, memwrite_q, resultsrc_q;
  logic [WIDTH-1:0] aluresult_q, writedata_q, pcplus4_q;
  logic [AW-1:0]    rd_q;

  logic             regwrite_d, memwrite_d, resultsrc_d;
  logic [WIDTH-1:0] aluresult_d, writedata_d, pcplus4_d;
  logic [AW-1:0]    rd_d;

  logic [WIDTH-1:0] src_a, src_b_fwd, src_b, alu_res;
  logic             mul_op, zero_e;

  assign mul_op = (ALUControlE == 3'b111);

  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = aluresult_q;
      default: src_a = RD1_E;
    endcase
    unique case (ForwardBE)
      2'b01:   src_b_fwd = ResultW;
      2'b10:   src_b_fwd = aluresult_q;
      default: src_b_fwd = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;
  end

  always_comb begin
    unique case (ALUControlE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = src_a ^ src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_res = src_a << src_b[3:0];
      default: alu_res = '0;
    endcase
  end

  assign zero_e    = (alu_res == '0);
  assign BusyE     = ((state_q == IDLE) && mul_op) || (state_q == RUN);
  assign PCSrcE    = ((BranchE & zero_e) | JumpE) & ~BusyE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // EX/MEM takes a bubble unless a normal op is in IDLE or the multiply is retiring.
  always_comb begin
    regwrite_d  = 1'b0;
    memwrite_d  = 1'b0;
    resultsrc_d = 1'b0;
    aluresult_d = '0;
    writedata_d = '0;
    rd_d        = '0;
    pcplus4_d   = '0;
    if (((state_q == IDLE) && !mul_op) || (state_q == DONE)) begin
      regwrite_d  = RegWriteE;
      memwrite_d  = MemWriteE;
      resultsrc_d = ResultSrcE;
      aluresult_d = (state_q == DONE) ? acc_q : alu_res;
      writedata_d = src_b_fwd;
      rd_d        = RD_E;
      pcplus4_d   = PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_op) begin
            mcand_q <= src_a;
            mult_q  <= src_b;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (mult_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          count_q <= count_q + 4'd1;
          if (count_q == 4'd15) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      aluresult_q <= '0;
      writedata_q <= '0;
      rd_q        <= '0;
      pcplus4_q   <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      rd_q        <= rd_d;
      pcplus4_q   <= pcplus4_d;
    end
  end

  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign ResultSrcM = resultsrc_q;
  assign ALUResultM = aluresult_q;
  assign WriteDataM = writedata_q;
  assign RD_M       = rd_q;
  assign PCPlus4M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle with hand-computed expected values.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE;
  logic [2:0]  ALUControlE;
  logic [15:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [2:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
  logic [15:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [2:0]  RD_M;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  execute_cycle #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    ALUControlE = op; RD1_E = a; RD2_E = b;
    ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    RegWriteE = 1'b1; ALUSrcE = 1'b0; MemWriteE = 1'b1; ResultSrcE = 1'b1;
    BranchE = 1'b0; JumpE = 1'b1; ALUControlE = 3'b000;
    RD1_E = 16'h1111; RD2_E = 16'h2222; Imm_Ext_E = 16'h0010; RD_E = 3'd6;
    PCE = 16'h0100; PCPlus4E = 16'h0104; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ResultW = 16'h0000;
    #1;
    tick();
    tick();
    chk("rst_alures", ALUResultM, 16'h0000);
    chk("rst_wdata", WriteDataM, 16'h0000);
    chk("rst_ctrl", {13'd0, RegWriteM, MemWriteM, ResultSrcM}, 16'h0000);
    chk("rst_rd_pc4", {RD_M, PCPlus4M[12:0]}, 16'h0000);
    chk("rst_busy", {15'd0, BusyE}, 16'h0000);
    chk("rst_pcsrc_jump", {15'd0, PCSrcE}, 16'h0001);
    chk("rst_pctarget", PCTargetE, 16'h0110);

    rst = 1'b0; JumpE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
    RegWriteE = 1'b1; RD_E = 3'd2; PCPlus4E = 16'h0008;
    alu_op(3'b000, 16'h1234, 16'h0FF0);
    tick();
    chk("add_res", ALUResultM, 16'h2224);
    chk("add_wdata", WriteDataM, 16'h0FF0);
    chk("add_regwrite", {15'd0, RegWriteM}, 16'h0001);
    chk("add_rd_pc4", {RD_M, PCPlus4M[12:0]}, {3'd2, 13'h0008});

    alu_op(3'b000, 16'h0002, 16'h0003);
    tick();
    chk("pre_fwd", ALUResultM, 16'h0005);
    alu_op(3'b001, 16'hAAAA, 16'h5555);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 16'h0003;
    tick();
    chk("fwd_sub", ALUResultM, 16'h0002);
    chk("fwd_wdata", WriteDataM, 16'h0003);
    alu_op(3'b000, 16'h0010, 16'h0020);
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    tick();
    chk("fwd_reserved", ALUResultM, 16'h0030);

    alu_op(3'b010, 16'h8001, 16'h1234); ALUSrcE = 1'b1; Imm_Ext_E = 16'h0003;
    tick();
    chk("and_imm", ALUResultM, 16'h0001);
    chk("imm_wdata", WriteDataM, 16'h1234);
    alu_op(3'b011, 16'h8001, 16'h1234); ALUSrcE = 1'b1;
    tick();
    chk("or_imm", ALUResultM, 16'h8003);
    alu_op(3'b100, 16'h8001, 16'h1234); ALUSrcE = 1'b1;
    tick();
    chk("xor_imm", ALUResultM, 16'h8002);
    alu_op(3'b101, 16'h8001, 16'h1234); ALUSrcE = 1'b1;
    tick();
    chk("slt_neg", ALUResultM, 16'h0001);
    alu_op(3'b101, 16'h0003, 16'h8001);
    tick();
    chk("slt_pos", ALUResultM, 16'h0000);
    alu_op(3'b110, 16'h8001, 16'h1234); ALUSrcE = 1'b1;
    tick();
    chk("sll", ALUResultM, 16'h0008);

    alu_op(3'b001, 16'h0007, 16'h0007);
    BranchE = 1'b1; RegWriteE = 1'b0; PCE = 16'h0040; Imm_Ext_E = 16'hFFF8;
    #1;
    chk("beq_taken", {15'd0, PCSrcE}, 16'h0001);
    chk("beq_target", PCTargetE, 16'h0038);
    RD2_E = 16'h0006;
    #1;
    chk("beq_not_taken", {15'd0, PCSrcE}, 16'h0000);
    tick();
    BranchE = 1'b0;

    // first MUL; RD1/RD2 change while busy to show operands were captured
    alu_op(3'b111, 16'h0123, 16'h0045);
    RegWriteE = 1'b1; RD_E = 3'd5; PCPlus4E = 16'h0100;
    #1;
    chk("mul1_busy_idle", {15'd0, BusyE}, 16'h0001);
    for (int k = 1; k <= 16; k++) begin
      tick();
      RD1_E = 16'hDEAD; RD2_E = 16'hBEEF;
      chk("mul1_busy_run", {15'd0, BusyE}, 16'h0001);
      chk("mul1_bubble", {15'd0, RegWriteM}, 16'h0000);
    end
    tick();
    chk("mul1_done_busy", {15'd0, BusyE}, 16'h0000);
    chk("mul1_done_bubble", {15'd0, RegWriteM}, 16'h0000);
    tick();
    chk("mul1_res", ALUResultM, 16'h4E6F);
    chk("mul1_regwrite", {15'd0, RegWriteM}, 16'h0001);
    chk("mul1_rd_pc4", {RD_M, PCPlus4M[12:0]}, {3'd5, 13'h0100});

    // back-to-back MUL
    alu_op(3'b111, 16'hFFFF, 16'hFFFF);
    #1;
    chk("mul2_busy_idle", {15'd0, BusyE}, 16'h0001);
    for (int k = 1; k <= 17; k++) tick();
    chk("mul2_done_busy", {15'd0, BusyE}, 16'h0000);
    tick();
    chk("mul2_res", ALUResultM, 16'h0001);

    // abort a multiply in its 8th RUN cycle
    alu_op(3'b111, 16'h0003, 16'h0004); JumpE = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    chk("abort_busy_run", {15'd0, BusyE}, 16'h0001);
    chk("abort_pcsrc_forced", {15'd0, PCSrcE}, 16'h0000);
    rst = 1'b1; JumpE = 1'b0;
    alu_op(3'b000, 16'h0002, 16'h0003);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", {15'd0, BusyE}, 16'h0000);
    chk("abort_res", ALUResultM, 16'h0000);
    chk("abort_regwrite", {15'd0, RegWriteM}, 16'h0000);
    tick();
    chk("post_abort_add", ALUResultM, 16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
